debounce_toggle_gen: RTL and testbench
======================================

Name: debounce_toggle_gen

Overview:
- Cleans a raw, asynchronous push-button or toggle-request input and produces the single-cycle `t` strobe that drives the T flip-flop stage directly downstream.
- Internal pipeline: 2-flop synchroniser, then debounce counter/FSM, then registered one-cycle pulse.
- Also reports the debounced level and a wrapping count of accepted presses.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronised-high (or low) cycles needed to accept a press (or release). Legal minimum is 2.
- REPEAT_CYCLES, 8: cycles between auto-repeat pulses while held. Used only with the optional feature.
- CNT_W, 8: width of press_count.

Ports:
- clk  input  1  system clock; all logic on its rising edge
- reset  input  1  synchronous, active-low reset (asserted when 0)
- btn_in  input  1  raw asynchronous button/request level; may bounce
- t  output  1  one-cycle toggle strobe to the T flip-flop; registered
- stable  output  1  debounced button level; registered
- press_count  output  CNT_W  number of t pulses issued; wraps modulo 2^CNT_W

Behaviour:
- Reset (reset==0 at a rising clk edge):
  - sync flops, debounce counter, repeat counter and press_count go to 0.
  - FSM goes to IDLE; t=0, stable=0.
  - Reset overrides all other activity.
- Reset mid-debounce or mid-hold: the operation is aborted and no t pulse is emitted for it.
- Synchroniser: ff1<=btn_in, s<=ff1. The FSM uses only s.
- FSM states: IDLE, DEB_PRESS, HELD, DEB_RELEASE.
  - IDLE: stable=0. If s==1: go to DEB_PRESS, cnt<=0.
  - DEB_PRESS:
    - s==0: back to IDLE, cnt<=0 (bounce rejected, no pulse).
    - s==1 and cnt<DEBOUNCE_CYCLES-1: cnt<=cnt+1.
    - s==1 and cnt==DEBOUNCE_CYCLES-1: go to HELD; t<=1 for exactly one cycle; stable<=1; press_count<=press_count+1.
  - HELD: stable=1. If s==0: go to DEB_RELEASE, cnt<=0.
  - DEB_RELEASE:
    - s==1: back to HELD, cnt<=0 (no pulse, stable stays 1).
    - s==0 for DEBOUNCE_CYCLES cycles (same counting rule): go to IDLE, stable<=0. No pulse on release.
- Latency: btn_in high before rising edge k and held steady gives t=1 and stable=1 in the cycle after edge k+2+DEBOUNCE_CYCLES (edge k+6 with default 4).
- t is never high for two consecutive cycles; t is 0 in all states except on the DEB_PRESS to HELD edge (and auto-repeat).
- Counter width is $clog2(DEBOUNCE_CYCLES) bits minimum; it must never overflow.
- press_count wraps silently from 2^CNT_W-1 to 0.
- btn_in changing in the same cycle reset deasserts: ignored until it passes through the synchroniser.

Optional Feature:
- Macro: DEBOUNCE_TOGGLE_AUTOREPEAT_EN
- Defined:
  - In HELD, a repeat counter counts cycles with s==1.
  - On reaching REPEAT_CYCLES-1: emit t (one cycle), increment press_count, clear the repeat counter.
  - Repeat counter clears on entry to HELD and whenever leaving HELD.
  - A return from DEB_RELEASE to HELD restarts the repeat interval.
- Undefined: no repeat counter is synthesised; exactly one t per accepted press. REPEAT_CYCLES is ignored.

Decomposition:
- Package debounce_toggle_pkg holds:
  - the FSM state enum (IDLE, DEB_PRESS, HELD, DEB_RELEASE, 2-bit encoding);
  - default constants for DEBOUNCE_CYCLES and REPEAT_CYCLES.
- Sub-module: sync_2ff (1-bit, synchronous active-low reset to 0), instantiated once for btn_in.

Test Plan:
- Reset held low 3 cycles with btn_in=1 → t=0, stable=0, press_count=0 throughout; after release, t pulses at the 7th edge (DEBOUNCE_CYCLES=4).
- Clean press: btn_in 0→1 before edge 10, held 20 cycles → exactly one t pulse after edge 16; stable=1 from same cycle; press_count=1.
- Bounce: btn_in high 2 cycles, low 1, high 2, then low → no t, stable stays 0, press_count=0.
- Release bounce: from HELD, btn_in low 2 cycles then high → stays HELD, no pulse; low 6 cycles → stable=0, no pulse.
- Wrap: CNT_W=2, five clean presses → press_count sequence 1,2,3,0,1; the downstream T flip-flop q toggles 5 times.
- With DEBOUNCE_TOGGLE_AUTOREPEAT_EN and REPEAT_CYCLES=8: hold 30 cycles after acceptance → t at acceptance, then every 8 cycles (4 pulses total). Without the macro → 1 pulse.

Source files
------------

// File: rtl/debounce_toggle_pkg.sv
// Shared types and defaults for the button debounce / toggle-strobe block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package debounce_toggle_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } deb_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_REPEAT_CYCLES   = 8;
  localparam int DEF_CNT_W           = 8;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; free-running every cycle.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic ff1;

  // Shift the raw level through two flops; both clear on reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ff1 <= 1'b0;
      q   <= 1'b0;
    end else begin
      ff1 <= d;
      q   <= ff1;
    end
  end

endmodule

// File: rtl/debounce_toggle_gen.sv
// Debounces a raw button and emits a one-cycle t strobe per accepted press; optional auto-repeat under DEBOUNCE_TOGGLE_AUTOREPEAT_EN.
// Latency: t/stable rise after edge k+2+DEBOUNCE_CYCLES for btn_in high before edge k.
// Backpressure: none; t is a fire-and-forget strobe to the downstream T flip-flop.
module debounce_toggle_gen
  import debounce_toggle_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_in,
  output logic             t,
  output logic             stable,
  output logic [CNT_W-1:0] press_count
);

  localparam int            DW       = cnt_bits(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          s;
  deb_state_e    state, state_nxt;
  logic [DW-1:0] cnt, cnt_nxt;
  logic          t_nxt;
  logic          stable_nxt;

`ifdef DEBOUNCE_TOGGLE_AUTOREPEAT_EN
  localparam int            RW       = cnt_bits(REPEAT_CYCLES);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rep_cnt, rep_cnt_nxt;
`else
  localparam int unused_repeat_cycles = REPEAT_CYCLES;
`endif

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (s)
  );

  // Next-state logic: the counter only ever runs up to DEB_LAST, so it cannot wrap.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    t_nxt      = 1'b0;
    stable_nxt = stable;
`ifdef DEBOUNCE_TOGGLE_AUTOREPEAT_EN
    rep_cnt_nxt = '0;
`endif
    case (state)
      IDLE: begin
        stable_nxt = 1'b0;
        if (s) begin
          state_nxt = DEB_PRESS;
          cnt_nxt   = '0;
        end
      end
      DEB_PRESS: begin
        if (!s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt  = HELD;
          cnt_nxt    = '0;
          t_nxt      = 1'b1;
          stable_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + DW'(1);
        end
      end
      HELD: begin
        stable_nxt = 1'b1;
        if (!s) begin
          state_nxt = DEB_RELEASE;
          cnt_nxt   = '0;
        end else begin
`ifdef DEBOUNCE_TOGGLE_AUTOREPEAT_EN
          if (rep_cnt == REP_LAST) begin
            t_nxt       = 1'b1;
            rep_cnt_nxt = '0;
          end else begin
            rep_cnt_nxt = rep_cnt + RW'(1);
          end
`endif
        end
      end
      DEB_RELEASE: begin
        if (s) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt  = IDLE;
          cnt_nxt    = '0;
          stable_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + DW'(1);
        end
      end
      default: begin
        state_nxt  = IDLE;
        cnt_nxt    = '0;
        stable_nxt = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs; reset aborts any press in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      t           <= 1'b0;
      stable      <= 1'b0;
      press_count <= '0;
`ifdef DEBOUNCE_TOGGLE_AUTOREPEAT_EN
      rep_cnt     <= '0;
`endif
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      t      <= t_nxt;
      stable <= stable_nxt;
      if (t_nxt) begin
        press_count <= press_count + CNT_W'(1);
      end
`ifdef DEBOUNCE_TOGGLE_AUTOREPEAT_EN
      rep_cnt <= rep_cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_debounce_toggle_gen.sv
// Randomised bench with a run-length reference model and a queue-based scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_debounce_toggle_gen;
  import debounce_toggle_pkg::*;

  localparam int D  = DEF_DEBOUNCE_CYCLES;
  localparam int R  = DEF_REPEAT_CYCLES;
  localparam int CW = 2;

  logic          clk    = 1'b0;
  logic          reset  = 1'b0;
  logic          btn_in = 1'b0;
  logic          t;
  logic          stable;
  logic [CW-1:0] press_count;

  debounce_toggle_gen #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_CYCLES   (R),
    .CNT_W           (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_in      (btn_in),
    .t           (t),
    .stable      (stable),
    .press_count (press_count)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  typedef struct {int cyc; int count;} pulse_t;
  typedef struct {int cyc; bit lvl;}   lvl_t;
  pulse_t pq[$];
  lvl_t   sq[$];

  // Reference model state: synchroniser delay line plus run-length bookkeeping.
  bit m_ff1, m_s, m_lvl, m_rst_seen;
  int m_run, m_since, m_count, m_total_pulses;

  // Downstream T flip-flop driven by the DUT strobe.
  bit q_tff = 1'b0;
  int toggles = 0;
  bit prev_t = 1'b0;
  bit prev_stable = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic emit_pulse();
    m_count = (m_count + 1) % (1 << CW);
    m_total_pulses++;
    pq.push_back('{cyc, m_count});
  endtask

  // Model: the level flips once the synchronised input has disagreed with it for D+1 samples.
  always @(posedge clk) begin : model_b
    bit samp;
    cyc++;
    if (!reset) begin
      if (m_lvl) sq.push_back('{cyc, 1'b0});
      m_ff1 = 0; m_s = 0; m_lvl = 0; m_run = 0; m_since = -1; m_count = 0;
      m_rst_seen = 1;
    end else begin
      m_rst_seen = 0;
      samp  = m_s;
      m_s   = m_ff1;
      m_ff1 = btn_in;
      if (samp != m_lvl) begin
        m_run++;
        m_since = -1;
        if (m_run == D + 1) begin
          m_lvl = samp;
          m_run = 0;
          sq.push_back('{cyc, samp});
          if (samp) begin
            m_since = 0;
            emit_pulse();
          end
        end
      end else begin
        m_run = 0;
        if (m_lvl) begin
          if (m_since < 0) m_since = 0;
          else begin
            m_since++;
`ifdef DEBOUNCE_TOGGLE_AUTOREPEAT_EN
            if (m_since == R) begin
              m_since = 0;
              emit_pulse();
            end
`endif
          end
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT strobes t or moves stable.
  always @(negedge clk) begin : monitor_b
    pulse_t p;
    lvl_t   l;
    if (m_rst_seen) begin
      check("reset_t", t, 0);
      check("reset_stable", stable, 0);
      check("reset_press_count", press_count, 0);
    end
    while (pq.size() > 0 && pq[0].cyc < cyc) begin
      n_total++;
      $display("FAIL missed_t: no strobe seen, required at cycle %0d", pq[0].cyc);
      void'(pq.pop_front());
    end
    while (sq.size() > 0 && sq[0].cyc < cyc) begin
      n_total++;
      $display("FAIL missed_stable: no change seen, required to %0d at cycle %0d", sq[0].lvl, sq[0].cyc);
      void'(sq.pop_front());
    end
    if (t === 1'b1) begin
      check("t_not_consecutive", prev_t, 0);
      if (pq.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_t: t=1 but no strobe required (cycle %0d)", cyc);
      end else begin
        p = pq.pop_front();
        check("t_cycle", cyc, p.cyc);
        check("press_count", press_count, p.count);
      end
      q_tff = ~q_tff;
      toggles++;
    end
    if (stable !== prev_stable && cyc > 1) begin
      if (sq.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_stable: stable=%0d with no change required (cycle %0d)", stable, cyc);
      end else begin
        l = sq.pop_front();
        check("stable_cycle", cyc, l.cyc);
        check("stable_level", stable, l.lvl);
      end
    end
    prev_t      = (t === 1'b1);
    prev_stable = (stable === 1'b1);
  end

  task automatic drive(input bit lvl, input int n);
    btn_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset(input bit lvl);
    reset = 1'b0;
    drive(lvl, 2);
    reset = 1'b1;
  endtask

  initial begin
    // Reset held for three edges with the button already pressed.
    reset = 1'b0;
    drive(1, 3);
    reset = 1'b1;
    drive(1, 15);
    drive(0, 12);
    // Clean press.
    drive(1, 20);
    drive(0, 12);
    // Press bounce, rejected.
    drive(1, 2); drive(0, 1); drive(1, 2); drive(0, 12);
    // Release bounce, then real release.
    drive(1, 12); drive(0, 2); drive(1, 6); drive(0, 12);
    // Five clean presses wrap the 2-bit count.
    repeat (5) begin
      drive(1, 10);
      drive(0, 10);
    end
    // Long hold (auto-repeat when enabled).
    drive(1, 36);
    drive(0, 12);
    // Reset mid-debounce and mid-hold.
    drive(1, 4);
    pulse_reset(1);
    drive(1, 12);
    pulse_reset(1);
    drive(1, 12);
    drive(0, 12);
    // Random segments with occasional resets.
    repeat (120) begin
      if ($urandom_range(0, 19) == 0) pulse_reset(1'($urandom_range(0, 1)));
      drive(1'($urandom_range(0, 1)), $urandom_range(1, 12));
    end
    drive(0, 20);
    check("pending_pulses", pq.size(), 0);
    check("pending_stable", sq.size(), 0);
    check("tff_toggles", toggles, m_total_pulses);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
